sdram_log_sequencer: RTL
========================

// Module: sdram_log_sequencer
// PURPOSE
// Command-side initiator for the SDRAM controller. Appends 16-bit log words to SDRAM at
// sequential linear addresses and, on request, dumps the logged region back out.
// Owns memory traversal (bank/row/col generation), the command handshake with the
// controller, fill tracking and timeout detection. Sits between the avionics data
// packer and the SDRAM controller.
// PARAMETERS
// MAX_ADDR     24'hFFFFFF  last writable linear address (inclusive)
// TIMEOUT_CYC  1024        cycles allowed per controller transaction before abort
// PORTS
// CLK_48MHZ    in   1   system clock; all logic on rising edge
// RESET_N      in   1   asynchronous, active-low reset
// INIT_DONE    in   1   controller power-up/mode-register sequence complete
// WR_VALID     in   1   log word available
// WR_DATA      in   16  log word
// WR_READY     out  1   word accepted when WR_VALID & WR_READY
// DUMP_START   in   1   one-cycle pulse: read back addresses 0..WR_PTR-1
// RD_VALID     out  1   dump word valid
// RD_DATA      out  16  dump word
// RD_READY     in   1   downstream accepts dump word
// CMD_OUT      out  2   to controller CMD_IN: 0 idle, 1 read, 2 write (3 never driven)
// A_BANK       out  2   linear addr[23:22]
// A_ROW        out  13  linear addr[21:9]
// A_COL        out  9   linear addr[8:0]
// D_OUT        out  16  write data to controller D_IN
// CTRL_STATUS  in   1   controller STATUS: 1 = ready/idle, 0 = busy
// CTRL_DATA    in   16  controller DATA_READ
// WR_PTR       out  24  next linear write address (= words logged)
// FULL         out  1   sticky: MAX_ADDR written, logging stopped
// DUMPING      out  1   dump in progress
// DUMP_DONE    out  1   one-cycle pulse after final dump word accepted
// TIMEOUT_ERR  out  1   sticky: a controller transaction exceeded TIMEOUT_CYC
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, WR_PTR=0, read pointer=0, dump-pending=0.
// - States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_HOLD.
// - WR_READY=1 only in IDLE with INIT_DONE=1, CTRL_STATUS=1, FULL=0, DUMPING=0.
// - IDLE: write accept -> latch WR_DATA to D_OUT, addr=WR_PTR, CMD_OUT=2, go WR_ISSUE.
//   Else dump-pending & WR_PTR!=0 -> DUMPING=1, rd_ptr=0, CMD_OUT=1, go RD_ISSUE.
//   Write wins over dump when both eligible in the same cycle; dump stays pending.
// - DUMP_START latched into dump-pending (any state); ignored while DUMPING=1.
//   WR_PTR=0 at dump eligibility -> pending cleared, DUMP_DONE pulses, no reads.
// - *_ISSUE: hold CMD_OUT/addr/D_OUT until CTRL_STATUS sampled 0 (accepted); then
//   CMD_OUT=0, go *_WAIT. *_WAIT: wait CTRL_STATUS=1 (complete).
// - WR_WAIT complete: WR_PTR+=1; if written addr==MAX_ADDR set FULL (no wrap); IDLE.
// - RD_WAIT complete: RD_DATA<=CTRL_DATA same edge, RD_VALID=1, go RD_HOLD.
// - RD_HOLD: RD_VALID/RD_DATA stable until RD_READY; on accept rd_ptr+=1; if
//   rd_ptr+1==WR_PTR -> DUMPING=0, DUMP_DONE pulse, IDLE; else CMD_OUT=1, RD_ISSUE.
// - Address outputs always the linear address split as listed; addresses held
//   constant for entire transaction.
// - Timeout: counter cleared on entering *_ISSUE, counts in ISSUE+WAIT; reaching
//   TIMEOUT_CYC -> CMD_OUT=0, TIMEOUT_ERR=1, pointers unchanged, DUMPING=0, IDLE.
//   TIMEOUT_ERR clears only on reset; operation continues.
// - INIT_DONE=0: no new transaction starts; in-flight transaction completes.
// - Reset mid-transaction: immediate return to reset values; logged data considered lost.
// TESTING
// - Reset, INIT_DONE=1, 3 writes 0xA001..0xA003, controller model busy 4 cycles ->
//   CMD_OUT=2 at addr 0,1,2, WR_PTR=3, D_OUT matches each word.
// - WR_PTR=3, DUMP_START, RD_READY held low 5 cycles on word 1 -> RD_DATA 0xA001..
//   0xA003 in order, RD_VALID/RD_DATA stable while stalled, DUMP_DONE once.
// - MAX_ADDR=24'h000201, write 0x202 words -> addr 0x200 gives BANK=0,ROW=1,COL=0;
//   FULL=1 after addr 0x201, WR_READY=0, further WR_VALID ignored.
// - WR_VALID and DUMP_START same cycle in IDLE -> write first, dump follows.
// - Controller holds CTRL_STATUS=0 forever, TIMEOUT_CYC=16 -> TIMEOUT_ERR=1 after 16
//   cycles, CMD_OUT=0, WR_PTR unchanged.
// - DUMP_START with WR_PTR=0 -> no CMD_OUT=1, DUMP_DONE pulses one cycle.

Source files
------------

// File: rtl/sdram_log_sequencer.sv
// Command-side initiator for the SDRAM controller: appends 16-bit log words at
// sequential linear addresses and dumps the logged region back on request.
module sdram_log_sequencer #(
    parameter logic [23:0] MAX_ADDR    = 24'hFFFFFF,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET_N,
    input  logic        INIT_DONE,
    input  logic        WR_VALID,
    input  logic [15:0] WR_DATA,
    output logic        WR_READY,
    input  logic        DUMP_START,
    output logic        RD_VALID,
    output logic [15:0] RD_DATA,
    input  logic        RD_READY,
    output logic [1:0]  CMD_OUT,
    output logic [1:0]  A_BANK,
    output logic [12:0] A_ROW,
    output logic [8:0]  A_COL,
    output logic [15:0] D_OUT,
    input  logic        CTRL_STATUS,
    input  logic [15:0] CTRL_DATA,
    output logic [23:0] WR_PTR,
    output logic        FULL,
    output logic        DUMPING,
    output logic        DUMP_DONE,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 1);

    state_t        state_q, state_d;
    logic [23:0]   wr_ptr_q, wr_ptr_d;
    logic [23:0]   rd_ptr_q, rd_ptr_d;
    logic [23:0]   addr_q, addr_d;
    logic [15:0]   d_out_q, d_out_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          full_q, full_d;
    logic          dumping_q, dumping_d;
    logic          dump_done_q, dump_done_d;
    logic          timeout_q, timeout_d;
    logic          dump_pend_q, dump_pend_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_accept, dump_ok, in_xact, tmo_hit;
    logic [23:0]   rd_ptr_next;

    assign wr_accept   = (state_q == S_IDLE) & INIT_DONE & CTRL_STATUS & ~full_q & ~dumping_q;
    assign dump_ok     = (state_q == S_IDLE) & dump_pend_q & INIT_DONE & CTRL_STATUS;
    assign in_xact     = (state_q == S_WR_ISSUE) | (state_q == S_WR_WAIT) |
                         (state_q == S_RD_ISSUE) | (state_q == S_RD_WAIT);
    assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign rd_ptr_next = rd_ptr_q + 24'd1;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_d      = addr_q;
        d_out_d     = d_out_q;
        rd_data_d   = rd_data_q;
        cmd_d       = cmd_q;
        tmo_cnt_d   = in_xact ? tmo_cnt_q + TW'(1) : tmo_cnt_q;
        full_d      = full_q;
        dumping_d   = dumping_q;
        dump_done_d = 1'b0;
        timeout_d   = timeout_q;
        dump_pend_d = dump_pend_q | (DUMP_START & ~dumping_q);
        rd_valid_d  = rd_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (wr_accept && WR_VALID) begin
                    d_out_d   = WR_DATA;
                    addr_d    = wr_ptr_q;
                    cmd_d     = CMD_WR;
                    tmo_cnt_d = '0;
                    state_d   = S_WR_ISSUE;
                end else if (dump_ok) begin
                    dump_pend_d = 1'b0;
                    if (wr_ptr_q == 24'd0) begin
                        dump_done_d = 1'b1;
                    end else begin
                        dumping_d = 1'b1;
                        rd_ptr_d  = 24'd0;
                        addr_d    = 24'd0;
                        cmd_d     = CMD_RD;
                        tmo_cnt_d = '0;
                        state_d   = S_RD_ISSUE;
                    end
                end
            end
            S_WR_ISSUE, S_RD_ISSUE: begin
                if (!CTRL_STATUS) begin
                    cmd_d   = CMD_NOP;
                    state_d = (state_q == S_WR_ISSUE) ? S_WR_WAIT : S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (CTRL_STATUS) begin
                    if (wr_ptr_q != 24'hFFFFFF) wr_ptr_d = wr_ptr_q + 24'd1;
                    if (addr_q == MAX_ADDR) full_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (CTRL_STATUS) begin
                    rd_data_d  = CTRL_DATA;
                    rd_valid_d = 1'b1;
                    state_d    = S_RD_HOLD;
                end
            end
            S_RD_HOLD: begin
                if (RD_READY) begin
                    rd_valid_d = 1'b0;
                    rd_ptr_d   = rd_ptr_next;
                    if (rd_ptr_next == wr_ptr_q) begin
                        dumping_d   = 1'b0;
                        dump_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        addr_d    = rd_ptr_next;
                        cmd_d     = CMD_RD;
                        tmo_cnt_d = '0;
                        state_d   = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort only when the transaction made no progress this cycle.
        if (in_xact && (state_d == state_q) && tmo_hit) begin
            cmd_d     = CMD_NOP;
            timeout_d = 1'b1;
            dumping_d = 1'b0;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            d_out_q     <= '0;
            rd_data_q   <= '0;
            cmd_q       <= CMD_NOP;
            tmo_cnt_q   <= '0;
            full_q      <= 1'b0;
            dumping_q   <= 1'b0;
            dump_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            dump_pend_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            d_out_q     <= d_out_d;
            rd_data_q   <= rd_data_d;
            cmd_q       <= cmd_d;
            tmo_cnt_q   <= tmo_cnt_d;
            full_q      <= full_d;
            dumping_q   <= dumping_d;
            dump_done_q <= dump_done_d;
            timeout_q   <= timeout_d;
            dump_pend_q <= dump_pend_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign WR_READY    = wr_accept;
    assign RD_VALID    = rd_valid_q;
    assign RD_DATA     = rd_data_q;
    assign CMD_OUT     = cmd_q;
    assign A_BANK      = addr_q[23:22];
    assign A_ROW       = addr_q[21:9];
    assign A_COL       = addr_q[8:0];
    assign D_OUT       = d_out_q;
    assign WR_PTR      = wr_ptr_q;
    assign FULL        = full_q;
    assign DUMPING     = dumping_q;
    assign DUMP_DONE   = dump_done_q;
    assign TIMEOUT_ERR = timeout_q;

endmodule
